// File: rtl/uart_frame_rx_n.sv
// uart_frame_rx_n: header-synced UART frame receiver with XOR check, one-deep output holding register and sticky fault flags
module uart_frame_rx_n #(
  parameter int       CLK_HZ       = 100_000_000,
  parameter int       BAUD         = 921600,
  parameter int       FRAME_BYTES  = 3,
  parameter logic [7:0] HEADER     = 8'hA5,
  parameter bit       CHECK_EN     = 1'b1,
  parameter int       TIMEOUT_BITS = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx,
  output logic [8*FRAME_BYTES-1:0] frame_data,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic [3:0]               err,
  input  logic                     err_clr
);
  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int TMO  = TIMEOUT_BITS * DIV;
  localparam int CW   = $clog2(DIV);
  localparam int GW   = $clog2(TMO + 1);
  localparam int FW   = 8 * FRAME_BYTES;
  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bst_t;
  typedef enum logic [1:0] {F_HUNT, F_PAYLOAD, F_CHECK, F_DELIVER} fst_t;
  bst_t          bst_q, bst_d;
  fst_t          fst_q, fst_d;
  logic          s1_q, s2_q, s3_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [4:0]    idx_q, idx_d;
  logic [7:0]    csum_q, csum_d;
  logic [FW-1:0] buf_q, buf_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [FW-1:0] fd_q, fd_d;
  logic          fv_q, fv_d;
  logic [3:0]    err_q, err_d;
  logic          rxs, fall, sample_stop, byte_done, stop_err;
  logic          counting, timeout, csum_bad, deliver, load, ovr;
  assign rxs         = s2_q;
  assign fall        = s3_q & ~s2_q;
  assign frame_data  = fd_q;
  assign frame_valid = fv_q;
  assign err         = err_q;
  // state register: synchroniser, both FSMs, datapath and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      s3_q   <= 1'b1;
      bst_q  <= B_IDLE;
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      fst_q  <= F_HUNT;
      idx_q  <= '0;
      csum_q <= '0;
      buf_q  <= '0;
      gap_q  <= '0;
      fd_q   <= '0;
      fv_q   <= 1'b0;
      err_q  <= '0;
    end else begin
      s1_q   <= rx;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      bst_q  <= bst_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      fst_q  <= fst_d;
      idx_q  <= idx_d;
      csum_q <= csum_d;
      buf_q  <= buf_d;
      gap_q  <= gap_d;
      fd_q   <= fd_d;
      fv_q   <= fv_d;
      err_q  <= err_d;
    end
  end
  // byte FSM next state: start edge, mid-bit sampling, LSB-first shift
  always_comb begin
    bst_d = bst_q;
    cnt_d = cnt_q + CW'(1);
    bit_d = bit_q;
    sh_d  = sh_q;
    case (bst_q)
      B_IDLE: begin
        cnt_d = '0;
        if (fall) bst_d = B_START;
      end
      B_START: if (cnt_q == CW'(HALF - 1)) begin
        cnt_d = '0;
        bit_d = '0;
        bst_d = rxs ? B_IDLE : B_DATA;
      end
      B_DATA: if (cnt_q == CW'(DIV - 1)) begin
        cnt_d = '0;
        sh_d  = {rxs, sh_q[7:1]};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) bst_d = B_STOP;
      end
      default: if (cnt_q == CW'(DIV - 1)) begin
        cnt_d = '0;
        bst_d = B_IDLE;
      end
    endcase
  end
  // byte FSM outputs: stop-bit sample yields either a good byte or a framing fault
  always_comb begin
    sample_stop = (bst_q == B_STOP) && (cnt_q == CW'(DIV - 1));
    byte_done   = sample_stop & rxs;
    stop_err    = sample_stop & ~rxs;
  end
  // frame FSM outputs: gap timeout, checksum fault and delivery decisions
  always_comb begin
    counting = ((fst_q == F_PAYLOAD) || (fst_q == F_CHECK)) && (bst_q == B_IDLE);
    timeout  = counting && (gap_q == GW'(TMO - 1));
    csum_bad = (fst_q == F_CHECK) && byte_done && (sh_q != csum_q);
    deliver  = fst_q == F_DELIVER;
    load     = deliver && (!fv_q || frame_ready);
    ovr      = deliver && fv_q && !frame_ready;
  end
  // frame FSM next state: header hunt, payload shift-in (first byte ends in MSBs), checksum compare
  always_comb begin
    fst_d  = fst_q;
    idx_d  = idx_q;
    csum_d = csum_q;
    buf_d  = buf_q;
    gap_d  = (counting && !timeout) ? gap_q + GW'(1) : '0;
    if (stop_err || timeout) fst_d = F_HUNT;
    else case (fst_q)
      F_HUNT: if (byte_done && sh_q == HEADER) begin
        fst_d  = F_PAYLOAD;
        idx_d  = '0;
        csum_d = '0;
      end
      F_PAYLOAD: if (byte_done) begin
        buf_d  = FW'({buf_q, sh_q});
        csum_d = csum_q ^ sh_q;
        idx_d  = idx_q + 5'd1;
        if (idx_q == 5'(FRAME_BYTES - 1)) fst_d = CHECK_EN ? F_CHECK : F_DELIVER;
      end
      F_CHECK: if (byte_done) fst_d = (sh_q == csum_q) ? F_DELIVER : F_HUNT;
      default: fst_d = F_HUNT;
    endcase
  end
  // holding register and sticky flags; a new fault wins over err_clr
  always_comb begin
    fd_d  = load ? buf_q : fd_q;
    fv_d  = load | (fv_q & ~frame_ready);
    err_d = (err_clr ? 4'b0 : err_q) | {timeout, ovr, csum_bad, stop_err};
  end
endmodule

// File: tb/tb_uart_frame_rx_n.sv
// tb_uart_frame_rx_n: directed frames at default baud with hand-computed results
`timescale 1ns/1ps
module tb_uart_frame_rx_n;
  localparam int DIV = 100_000_000 / 921600;
  logic        clk = 1'b0;
  logic        rst, rx, frame_ready, err_clr;
  logic [23:0] frame_data;
  logic        frame_valid;
  logic [3:0]  err;
  int          nchk = 0, nerr = 0;
  int          rises = 0, hi = 0, r0 = 0, h0 = 0;
  logic        fv_prev = 1'b0;
  logic [23:0] last_data = '0;
  uart_frame_rx_n dut (
    .clk(clk), .rst(rst), .rx(rx), .frame_data(frame_data), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .err(err), .err_clr(err_clr)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (frame_valid && !fv_prev) begin
      rises++;
      last_data = frame_data;
    end
    if (frame_valid) hi++;
    fv_prev = frame_valid;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stp);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stp;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
  endtask
  task automatic idle(input int bits);
    rx = 1'b1;
    repeat (bits * DIV) @(negedge clk);
  endtask
  task automatic send_good(input logic [23:0] d);
    send_byte(8'hA5, 1'b1);
    send_byte(d[23:16], 1'b1);
    send_byte(d[15:8], 1'b1);
    send_byte(d[7:0], 1'b1);
    send_byte(d[23:16] ^ d[15:8] ^ d[7:0], 1'b1);
  endtask
  task automatic mark;
    r0 = rises;
    h0 = hi;
  endtask
  task automatic pulse_clr;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask
  initial begin
    #950_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1; rx = 1'b1; frame_ready = 1'b1; err_clr = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    check("rst_data", frame_data, 0);
    check("rst_valid", frame_valid, 0);
    check("rst_err", err, 0);
    idle(2);
    mark;
    send_good(24'h123456);
    idle(2);
    check("basic_frames", rises - r0, 1);
    check("basic_width", hi - h0, 1);
    check("basic_data", last_data, 24'h123456);
    check("basic_err", err, 0);
    mark;
    send_byte(8'h00, 1'b1); send_byte(8'hFF, 1'b1); send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    idle(2);
    check("hunt_frames", rises - r0, 1);
    check("hunt_data", last_data, 24'h010203);
    check("hunt_err", err, 0);
    mark;
    send_byte(8'hA5, 1'b1); send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1); send_byte(8'h71, 1'b1);
    idle(2);
    check("csum_frames", rises - r0, 0);
    check("csum_err", err, 4'b0010);
    pulse_clr;
    check("csum_clr", err, 0);
    frame_ready = 1'b0;
    mark;
    send_good(24'h123456);
    send_good(24'h010203);
    idle(2);
    check("ovr_frames", rises - r0, 1);
    check("ovr_valid", frame_valid, 1);
    check("ovr_data", frame_data, 24'h123456);
    check("ovr_err", err, 4'b0100);
    frame_ready = 1'b1;
    @(negedge clk);
    check("ovr_release", frame_valid, 0);
    pulse_clr;
    mark;
    send_byte(8'hA5, 1'b1); send_byte(8'h12, 1'b1);
    idle(25);
    send_byte(8'h34, 1'b1); send_byte(8'h56, 1'b1); send_byte(8'h70, 1'b1);
    idle(2);
    check("tmo_frames", rises - r0, 0);
    check("tmo_err", err, 4'b1000);
    pulse_clr;
    mark;
    send_good(24'h0A0B0C);
    idle(2);
    check("tmo_next_frames", rises - r0, 1);
    check("tmo_next_data", last_data, 24'h0A0B0C);
    check("tmo_next_err", err, 0);
    mark;
    send_byte(8'hA5, 1'b1); send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b0);
    idle(1);
    send_byte(8'h56, 1'b1); send_byte(8'h70, 1'b1);
    idle(2);
    check("stop_frames", rises - r0, 0);
    check("stop_err", err, 4'b0001);
    rx = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_data", frame_data, 0);
    check("mid_rst_valid", frame_valid, 0);
    check("mid_rst_err", err, 0);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    idle(12);
    mark;
    send_good(24'hA55A0F);
    idle(2);
    check("post_rst_frames", rises - r0, 1);
    check("post_rst_data", last_data, 24'hA55A0F);
    check("post_rst_err", err, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
